meta_write_rr_arbiter: RTL and testbench



---
 rtl/meta_arb_pkg.sv | 19 +
 rtl/rr_prio_select.sv | 23 ++
 rtl/meta_write_rr_arbiter.sv | 90 +++++++++
 tb/tb_meta_write_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meta_arb_pkg.sv
// Shared types and defaults for the meta-write arbiter: payload layout and a wrap helper.
package meta_arb_pkg;

  localparam int unsigned NInDef  = 4;
  localparam int unsigned IdxWDef = 6;
  localparam int unsigned WayWDef = 4;
  localparam int unsigned TagWDef = 20;

  typedef struct packed {
    logic [IdxWDef-1:0] idx;
    logic [WayWDef-1:0] way_en;
    logic [TagWDef-1:0] tag;
  } meta_req_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Wrap-around priority scan: first set bit of i_valid starting at i_ptr, modulo N_IN.
module rr_prio_select #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_IN-1:0]  i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_grant,
  output logic             o_any
);

  // Scan from the far end back toward i_ptr so the nearest valid requester wins last.
  always_comb begin
    o_grant = '0;
    o_any   = |i_valid;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (i_valid[(int'(i_ptr) + k) % N_IN]) begin
        o_grant = PTR_W'((int'(i_ptr) + k) % N_IN);
      end
    end
  end

endmodule

// File: rtl/meta_write_rr_arbiter.sv
// N-way arbiter for metadata writes: combinational grant, round-robin or fixed priority,
// with the grant locked onto a stalled requester until it fires.
module meta_write_rr_arbiter
  import meta_arb_pkg::*;
#(
  parameter int unsigned N_IN    = NInDef,
  parameter int unsigned IDX_W   = IdxWDef,
  parameter int unsigned WAY_W   = WayWDef,
  parameter int unsigned TAG_W   = TagWDef,
  parameter int unsigned RR_MODE = 1,
  localparam int unsigned PtrW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_IN-1:0]         io_in_valid,
  output logic [N_IN-1:0]         io_in_ready,
  input  logic [N_IN*IDX_W-1:0]   io_in_bits_idx,
  input  logic [N_IN*WAY_W-1:0]   io_in_bits_way_en,
  input  logic [N_IN*TAG_W-1:0]   io_in_bits_tag,
  input  logic                    io_out_ready,
  output logic                    io_out_valid,
  output logic [IDX_W-1:0]        io_out_bits_idx,
  output logic [WAY_W-1:0]        io_out_bits_way_en,
  output logic [TAG_W-1:0]        io_out_bits_tag,
  output logic [PtrW-1:0]         io_chosen
);

  logic [PtrW-1:0] r_ptr;
  logic            r_lock;
  logic [PtrW-1:0] r_lock_idx;

  logic [PtrW-1:0] w_scan_grant;
  logic            w_scan_any;
  logic            w_lock_hold;
  logic [PtrW-1:0] w_grant;
  logic            w_fire;
  logic            w_stall;
  logic [PtrW-1:0] w_ptr_next;

  rr_prio_select #(
    .N_IN  (N_IN),
    .PTR_W (PtrW)
  ) u_prio (
    .i_valid (io_in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_scan_grant),
    .o_any   (w_scan_any)
  );

  // A lock whose owner dropped valid is ignored so arbitration resumes in the same cycle.
  assign w_lock_hold  = r_lock & io_in_valid[r_lock_idx];
  assign w_grant      = w_lock_hold ? r_lock_idx : w_scan_grant;
  assign io_out_valid = w_lock_hold | w_scan_any;
  assign io_chosen    = io_out_valid ? w_grant : '0;
  assign w_fire       = io_out_valid & io_out_ready;
  assign w_stall      = io_out_valid & ~io_out_ready;
  assign w_ptr_next   = PtrW'(wrap_inc(32'(io_chosen), N_IN));

  assign io_out_bits_idx    = io_in_bits_idx[int'(io_chosen) * IDX_W +: IDX_W];
  assign io_out_bits_way_en = io_in_bits_way_en[int'(io_chosen) * WAY_W +: WAY_W];
  assign io_out_bits_tag    = io_in_bits_tag[int'(io_chosen) * TAG_W +: TAG_W];

  always_comb begin
    io_in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      io_in_ready[i] = io_out_ready & (io_chosen == PtrW'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      if ((RR_MODE != 0) && w_fire) begin
        r_ptr <= w_ptr_next;
      end
      r_lock <= w_stall;
      if (w_stall) begin
        r_lock_idx <= w_grant;
      end
    end
  end

  a_lock_owner_holds_valid : assert property (
    @(posedge clock) disable iff (reset) r_lock |-> io_in_valid[r_lock_idx]
  ) else $error("meta_write_rr_arbiter: locked requester dropped valid before firing");

endmodule

// File: tb/tb_meta_write_rr_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random run vs model.
module tb_meta_write_rr_arbiter;
  import meta_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 6;
  localparam int unsigned WW = 4;
  localparam int unsigned TW = 20;
  localparam int unsigned PW = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0]    in_valid, in_ready, fix_valid, fix_in_ready;
  logic [N*IW-1:0] in_idx;
  logic [N*WW-1:0] in_way;
  logic [N*TW-1:0] in_tag;
  logic            out_ready, out_valid, fix_out_ready, fix_out_valid;
  logic [IW-1:0]   out_idx, fix_out_idx;
  logic [WW-1:0]   out_way, fix_out_way;
  logic [TW-1:0]   out_tag, fix_out_tag;
  logic [PW-1:0]   chosen, fix_chosen;

  meta_req_t pay [N];

  always_comb begin
    in_idx = '0;
    in_way = '0;
    in_tag = '0;
    for (int i = 0; i < N; i++) begin
      in_idx[i*IW +: IW] = pay[i].idx;
      in_way[i*WW +: WW] = pay[i].way_en;
      in_tag[i*TW +: TW] = pay[i].tag;
    end
  end

  meta_write_rr_arbiter #(
    .N_IN (N), .IDX_W (IW), .WAY_W (WW), .TAG_W (TW), .RR_MODE (1)
  ) u_dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (in_valid),
    .io_in_ready        (in_ready),
    .io_in_bits_idx     (in_idx),
    .io_in_bits_way_en  (in_way),
    .io_in_bits_tag     (in_tag),
    .io_out_ready       (out_ready),
    .io_out_valid       (out_valid),
    .io_out_bits_idx    (out_idx),
    .io_out_bits_way_en (out_way),
    .io_out_bits_tag    (out_tag),
    .io_chosen          (chosen)
  );

  meta_write_rr_arbiter #(
    .N_IN (N), .IDX_W (IW), .WAY_W (WW), .TAG_W (TW), .RR_MODE (0)
  ) u_fix (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (fix_valid),
    .io_in_ready        (fix_in_ready),
    .io_in_bits_idx     (in_idx),
    .io_in_bits_way_en  (in_way),
    .io_in_bits_tag     (in_tag),
    .io_out_ready       (fix_out_ready),
    .io_out_valid       (fix_out_valid),
    .io_out_bits_idx    (fix_out_idx),
    .io_out_bits_way_en (fix_out_way),
    .io_out_bits_tag    (fix_out_tag),
    .io_chosen          (fix_chosen)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_pay(input string name, input int port);
    check({name, ".idx"}, 64'(out_idx), 64'(pay[port].idx));
    check({name, ".way"}, 64'(out_way), 64'(pay[port].way_en));
    check({name, ".tag"}, 64'(out_tag), 64'(pay[port].tag));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic          rdy;
    logic          ov;
    logic [PW-1:0] ch;
    logic [N-1:0]  ir;
  } vec_t;

  vec_t tbl [22];

  // Random-phase reference state
  int  m_ptr, m_lock, exp_c, prev_c;
  bit  pv [N];
  int  gen [N];
  int  fired [N];
  int  dut_fired [N];
  int  waitcnt [N];
  bit  expv, prev_stall;
  logic [N-1:0] exp_ir;

  initial begin
    for (int i = 0; i < N; i++) begin
      pay[i] = '{idx: IW'(i * 7 + 3), way_en: WW'(1 << i), tag: TW'(32'h1000 * (i + 1) + i)};
    end
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; fix_valid = '0; fix_out_ready = 1'b0;

    // Reset state (after the first edge so registers are defined)
    next_cycle();
    in_valid = 4'b0110; out_ready = 1'b0;
    @(negedge clock);
    check("rst.valid", 64'(out_valid), 64'd1);
    check("rst.chosen", 64'(chosen), 64'd1);
    check("rst.ready_lo", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("rst.ready_hi", 64'(in_ready), 64'b0010);
    in_valid = '0;
    #1;
    check("rst.idle_valid", 64'(out_valid), 64'd0);
    check("rst.idle_chosen", 64'(chosen), 64'd0);
    check_pay("rst.idle_pay", 0);
    next_cycle();
    reset = 1'b0;

    // Directed table; rows run back to back, so pointer/lock state carries across
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 1'b1, 1'b1, PW'(i % 4), N'(1 << (i % 4))};
    tbl[8]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[9]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[10] = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[11] = '{4'b0101, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[12] = '{4'b0101, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[13] = '{4'b0101, 1'b1, 1'b1, 2'd0, 4'b0001};
    tbl[14] = '{4'b0101, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[15] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001};
    tbl[16] = '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000};
    tbl[17] = '{4'b1001, 1'b1, 1'b1, 2'd0, 4'b0001};
    tbl[18] = '{4'b1001, 1'b0, 1'b1, 2'd3, 4'b0000};
    tbl[19] = '{4'b1011, 1'b0, 1'b1, 2'd3, 4'b0000};
    tbl[20] = '{4'b1011, 1'b1, 1'b1, 2'd3, 4'b1000};
    tbl[21] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    for (int r = 0; r < 22; r++) begin
      in_valid  = tbl[r].valid;
      out_ready = tbl[r].rdy;
      @(negedge clock);
      check($sformatf("tbl%0d.valid", r), 64'(out_valid), 64'(tbl[r].ov));
      check($sformatf("tbl%0d.chosen", r), 64'(chosen), 64'(tbl[r].ch));
      check($sformatf("tbl%0d.ready", r), 64'(in_ready), 64'(tbl[r].ir));
      check_pay($sformatf("tbl%0d", r), int'(tbl[r].ch));
      next_cycle();
    end

    // Fixed priority: lowest valid index always wins
    fix_valid = 4'b1010; fix_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check($sformatf("fix%0d.chosen", c), 64'(fix_chosen), 64'd1);
      check($sformatf("fix%0d.ready", c), 64'(fix_in_ready), 64'b0010);
      check($sformatf("fix%0d.tag", c), 64'(fix_out_tag), 64'(pay[1].tag));
      next_cycle();
    end
    fix_valid = '0; fix_out_ready = 1'b0;

    // Requester 3 fires with a known payload; pointer must wrap to 0
    pay[3] = '{idx: 6'h2A, way_en: 4'b1000, tag: 20'hABCDE};
    in_valid = 4'b0010; out_ready = 1'b1;
    @(negedge clock);
    check("p3.pre_chosen", 64'(chosen), 64'd1);
    next_cycle();
    in_valid = 4'b1000;
    @(negedge clock);
    check("p3.chosen", 64'(chosen), 64'd3);
    check("p3.idx", 64'(out_idx), 64'h2A);
    check("p3.way", 64'(out_way), 64'b1000);
    check("p3.tag", 64'(out_tag), 64'hABCDE);
    check("p3.ready", 64'(in_ready), 64'b1000);
    next_cycle();
    in_valid = 4'b1111; out_ready = 1'b0;
    @(negedge clock);
    check("p3.wrap", 64'(chosen), 64'd0);
    next_cycle();
    out_ready = 1'b1;
    next_cycle();

    // Lock on port 1, then a one-cycle reset pulse
    in_valid = 4'b0100;
    next_cycle();
    in_valid = 4'b0010; out_ready = 1'b0;
    @(negedge clock);
    check("rl.lock_chosen", 64'(chosen), 64'd1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; in_valid = 4'b1011; out_ready = 1'b1;
    @(negedge clock);
    check("rl.after_reset", 64'(chosen), 64'd0);
    check("rl.after_ready", 64'(in_ready), 64'b0001);
    next_cycle();
    in_valid = '0;
    next_cycle();

    // Random run against a reference model; valid is held until the payload fires
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m_ptr = 0; m_lock = -1; prev_stall = 1'b0; prev_c = 0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; gen[i] = 0; fired[i] = 0; dut_fired[i] = 0; waitcnt[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          gen[i]++;
          waitcnt[i] = 0;
          pay[i] = '{idx: IW'($urandom), way_en: WW'($urandom), tag: TW'($urandom)};
        end
        in_valid[i] = pv[i];
      end
      out_ready = 1'($urandom_range(0, 1));
      expv = 1'b0;
      exp_c = 0;
      if (m_lock >= 0) begin
        expv = 1'b1;
        exp_c = m_lock;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!expv && pv[(m_ptr + k) % N]) begin
            expv = 1'b1;
            exp_c = (m_ptr + k) % N;
          end
        end
      end
      exp_ir = out_ready ? N'(1 << exp_c) : '0;
      @(negedge clock);
      check("rnd.valid", 64'(out_valid), 64'(expv));
      check("rnd.chosen", 64'(chosen), 64'(exp_c));
      check("rnd.ready", 64'(in_ready), 64'(exp_ir));
      check_pay("rnd", exp_c);
      if (prev_stall) check("rnd.stable", 64'(chosen), 64'(prev_c));
      for (int i = 0; i < N; i++) dut_fired[i] += int'(in_valid[i] & in_ready[i]);
      prev_stall = expv && !out_ready;
      prev_c = exp_c;
      if (expv && out_ready) begin
        for (int j = 0; j < N; j++) begin
          if (j != exp_c && pv[j]) begin
            waitcnt[j]++;
            check("rnd.starve", 64'(waitcnt[j] > N - 1), 64'd0);
          end
        end
        fired[exp_c]++;
        pv[exp_c] = 1'b0;
        m_ptr = (exp_c + 1) % N;
        m_lock = -1;
      end else if (expv) begin
        m_lock = exp_c;
      end else begin
        m_lock = -1;
      end
      next_cycle();
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("rnd.fires%0d", i), 64'(dut_fired[i]), 64'(gen[i] - int'(pv[i])));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
